// File: rtl/core_pkg.sv
// Core-wide scalar types shared by the pipeline stages
// and the memory-side blocks.
package core_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [XLEN-1:0] data_t;

endpackage

// File: rtl/mem_arb_pkg.sv
// Types for the fetch/LSU memory bus arbiter:
// FSM states, owner encoding and byte-enable type.
package mem_arb_pkg;

  import core_pkg::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  typedef logic [XLEN/8-1:0] be_t;

endpackage

// File: rtl/arb_pick.sv
// Two-way requester selector; on contention LS wins
// unless fairness is on and LS had the last grant.
module arb_pick #(
  parameter bit FAIR = 1'b1
) (
  input  logic if_req,
  input  logic ls_req,
  input  logic last_ls,
  output logic pick_if,
  output logic pick_ls
);

  logic if_first;

  assign if_first = FAIR & last_ls;

  // one-hot winner from the request pair
  always_comb begin
    pick_if = 1'b0;
    pick_ls = 1'b0;
    unique case (1'b1)
      (if_req & ~ls_req): pick_if = 1'b1;
      (ls_req & ~if_req): pick_ls = 1'b1;
      (if_req &  ls_req): begin
        pick_if = if_first;
        pick_ls = ~if_first;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory bus between fetch and LSU,
// one transaction in flight, response routed to owner.
module mem_arbiter
  import core_pkg::*;
  import mem_arb_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  if_req,
  input  addr_t if_addr,
  input  logic  if_flush,
  output logic  if_gnt,
  output logic  if_rvalid,
  output data_t if_rdata,
  input  logic  ls_req,
  input  logic  ls_we,
  input  addr_t ls_addr,
  input  data_t ls_wdata,
  input  be_t   ls_be,
  output logic  ls_gnt,
  output logic  ls_rvalid,
  output data_t ls_rdata,
  output logic  mem_req,
  output logic  mem_we,
  output addr_t mem_addr,
  output data_t mem_wdata,
  output be_t   mem_be,
  input  logic  mem_gnt,
  input  logic  mem_rvalid,
  input  data_t mem_rdata
);

  arb_state_t state;
  logic       owner;
  logic       last_ls;
  logic       drop;
  logic       pick_if;
  logic       pick_ls;
  logic       idle;
  logic       resp;
  logic       flush_hit;

  arb_pick #(
    .FAIR    (FAIR)
  ) u_pick (
    .if_req  (if_req),
    .ls_req  (ls_req),
    .last_ls (last_ls),
    .pick_if (pick_if),
    .pick_ls (pick_ls)
  );

  assign idle      = (state == IDLE);
  assign resp      = (state == WAIT) & mem_rvalid;
  assign flush_hit = if_flush & (owner == OWNER_IF);

  // grants are combinational; held low while in reset
  assign if_gnt = rst_n & idle & pick_if;
  assign ls_gnt = rst_n & idle & pick_ls;

  // a flush landing with the response still kills it
  assign if_rvalid = resp & (owner == OWNER_IF)
                   & ~drop & ~if_flush;
  assign ls_rvalid = resp & (owner == OWNER_LS);

  assign if_rdata = mem_rdata;
  assign ls_rdata = mem_rdata;

  // transaction FSM with registered bus fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWNER_IF;
      last_ls   <= 1'b0;
      drop      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_if | pick_ls) begin
            state     <= ISSUE;
            mem_req   <= 1'b1;
            owner     <= pick_ls ? OWNER_LS : OWNER_IF;
            last_ls   <= pick_ls;
            mem_we    <= pick_ls & ls_we;
            mem_addr  <= pick_ls ? ls_addr : if_addr;
            mem_wdata <= pick_ls ? ls_wdata : '0;
            mem_be    <= pick_ls ? ls_be : '1;
          end
        end
        ISSUE: begin
          if (flush_hit) drop <= 1'b1;
          if (mem_gnt) begin
            state   <= WAIT;
            mem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state <= IDLE;
            drop  <= 1'b0;
          end else if (flush_hit) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory bus between instruction fetch (port IF, read-only) and the load/store unit (port LS, read/write). One transaction is in flight at a time. The arbiter chooses a requester, registers its address, data and byte enables, drives the bus request, and routes the response back to the owner. It sits between the fetch/LSU stages and the memory/bus adapter, and uses the core's `addr_t`/`data_t` types.

## Interface
Parameters:
- `FAIR`, 1, 1: alternate on contention; 0: LS always wins

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_gnt`
- `if_addr`  in  XLEN  fetch address (`addr_t`)
- `if_flush`  in  1  pulse; discard any pending IF response
- `if_gnt`  out  1  IF request captured
- `if_rvalid`  out  1  fetch data valid
- `if_rdata`  out  XLEN  fetch data (`data_t`)
- `ls_req`  in  1  LSU request; fields stable until `ls_gnt`
- `ls_we`  in  1  1 = store
- `ls_addr`  in  XLEN  address
- `ls_wdata`  in  XLEN  store data
- `ls_be`  in  XLEN/8  byte enables
- `ls_gnt`  out  1  LS request captured
- `ls_rvalid`  out  1  load data / store ack
- `ls_rdata`  out  XLEN  load data
- `mem_req`  out  1  bus request; held until `mem_gnt`
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/XLEN/XLEN/XLEN/8  registered bus fields
- `mem_gnt`  in  1  bus accepted request
- `mem_rvalid`  in  1  bus response valid (reads and writes)
- `mem_rdata`  in  XLEN  bus read data

## Operation
- FSM states are IDLE, ISSUE and WAIT.
- **IDLE.**
  - Selection happens when any request is high.
  - Winner: the only requester, or on contention LS, except when `FAIR`=1 and the last grant was LS, in which case IF wins.
  - The winner's `*_gnt` is asserted combinationally in that cycle.
  - The winner's fields are registered into `mem_*`, `owner` is recorded, and the FSM goes to ISSUE.
  - For IF winners: `mem_we`=0, `mem_be`=all ones, `mem_wdata`=0.
- **ISSUE.**
  - `mem_req`=1 with stable fields.
  - On `mem_gnt`, go to WAIT.
  - The request is never withdrawn.
- **WAIT.**
  - On `mem_rvalid`, pulse the owner's `*_rvalid` for one cycle with `*_rdata`=`mem_rdata`, then go to IDLE.
- **Flush.**
  - `if_flush` in ISSUE or WAIT with owner IF sets a `drop` flag.
  - The bus transaction completes normally, but `if_rvalid` is suppressed.
  - `drop` clears on return to IDLE.
  - `if_flush` in IDLE has no effect.
  - `if_flush` is ignored when owner is LS.
  - A flush in the same cycle as the IF response suppresses that response.
- `mem_rvalid` outside WAIT is ignored.
- Unselected requests remain pending; no `gnt` is issued for them.
- `*_rdata` may carry `mem_rdata` unconditionally; only `*_rvalid` is qualified.

## Timing
- Reset values:
  - state=IDLE
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be` all 0
  - `if_gnt`, `ls_gnt`, `if_rvalid`, `ls_rvalid` all 0
  - `drop`=0
  - last-grant=IF, so LS wins the first contention
- Zero-wait bus (`mem_gnt` and `mem_rvalid` in the cycles right after): req in cycle 0 → `gnt` cycle 0 → `mem_req` cycle 1 → `mem_rvalid`/`*_rvalid` cycle 2 → IDLE cycle 3.
- Throughput is one transaction per 3 cycles minimum.
- `mem_gnt` wait states extend ISSUE; response wait states extend WAIT.
- `mem_gnt` and `mem_rvalid` in the same cycle while in ISSUE: treat as accept only; the response must arrive in WAIT (bus contract).
- Reset asserted mid-transaction: immediate return to reset values; the in-flight bus transaction is abandoned (bus resets with the core).

## Structure
- `mem_arb_pkg` holds:
  - the state enum (`arb_state_t`: IDLE/ISSUE/WAIT)
  - owner encoding (`OWNER_IF`=0, `OWNER_LS`=1)
  - the `be_t` typedef (`logic [XLEN/8-1:0]`)
- `addr_t` and `data_t` are taken from the core type package.
- One sub-module, `arb_pick`: combinational two-way selector with `FAIR` and the last-grant input. Everything else stays in `mem_arbiter`.

## Test plan
- Single IF read at 0x0000_0100, zero-wait bus returning 0x0000_0013 → `if_gnt` c0, `mem_req`/`mem_addr`=0x100/`mem_we`=0 c1, `if_rvalid`/`if_rdata`=0x13 c2, `ls_rvalid` never.
- LS store 0xDEADBEEF to 0x2000 with be=0b0011, `mem_gnt` delayed 3 cycles → `mem_req` held 4 cycles with stable fields, then `ls_rvalid` on the ack.
- Both request continuously with `FAIR`=1 → grant order LS, IF, LS, IF. With `FAIR`=0 → LS only; IF stays pending with `if_gnt`=0.
- IF read granted, `if_flush` pulsed in WAIT, then `mem_rvalid` → `if_rvalid` stays 0; the next IF request completes normally.
- `rst_n` dropped during WAIT → all outputs 0 asynchronously. After release, an LS request proceeds from IDLE, and a stray `mem_rvalid` while IDLE produces no `*_rvalid`.
